// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter.
// Optional build macro: UART_ARB_FIXED_PRIO_EN selects fixed-priority picking.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    sIDLE  = 2'd0,
    sSEND  = 2'd1,
    sDRAIN = 2'd2,
    sGAP   = 2'd3
  } arb_state_e;

  localparam int unsigned DEFAULT_DATA_W = 8;

  // Gap counter width; a zero-length gap still gets a 1-bit counter.
  function automatic int unsigned gap_cnt_w(input int unsigned gap);
    return (gap < 1) ? 1 : $clog2(gap + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational requester picker for the UART TX arbiter.
// Default: round-robin starting after last_idx.
// With UART_ARB_FIXED_PRIO_EN defined: lowest set index wins, last_idx ignored.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic found;

  // Scan the request vector and return the first eligible index.
  always_comb begin
    int unsigned cand;
    valid = |req;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
`else
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_idx) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        idx   = IDX_W'(cand);
        found = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers.
// Picks a requester, latches its byte, strobes tx_start, follows tx_busy
// through the byte, then waits GAP_CYCLES idle clocks before re-arbitrating.
// Optional build macro: UART_ARB_FIXED_PRIO_EN (fixed priority, index 0 highest).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      tx_busy,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  output logic                      arb_busy
);

  localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W    = gap_cnt_w(GAP_CYCLES);
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  arb_state_e           state_q, state_d;
  logic [CNT_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]     last_idx_q, last_idx_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 tx_start_q, tx_start_d;
  logic [DATA_W-1:0]    tx_data_q, tx_data_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req      (req),
    .last_idx (last_idx_q),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  // Next-state, gap counter and output register inputs.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    last_idx_d = last_idx_q;
    grant_d    = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      sIDLE: begin
        if (pick_valid && !tx_busy) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == pick_idx) begin
              tx_data_d  = req_data[i*DATA_W +: DATA_W];
              grant_d[i] = 1'b1;
            end
          end
          tx_start_d = 1'b1;
`ifndef UART_ARB_FIXED_PRIO_EN
          last_idx_d = pick_idx;
`endif
          state_d    = sSEND;
        end
      end
      sSEND: begin
        if (tx_busy) state_d = sDRAIN;
      end
      sDRAIN: begin
        if (!tx_busy) begin
          if (GAP_CYCLES > 0) state_d = sGAP;
          else                state_d = sIDLE;
        end
      end
      sGAP: begin
        if (gap_cnt_q == CNT_W'(GAP_LAST)) begin
          gap_cnt_d = '0;
          state_d   = sIDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = sIDLE;
    endcase
  end

  // State and output registers; reset takes effect immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= sIDLE;
      gap_cnt_q  <= '0;
      last_idx_q <= IDX_W'(NUM_REQ - 1);
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      last_idx_q <= last_idx_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign grant    = grant_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign arb_busy = (state_q != sIDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a transaction-level reference model.
// Honors UART_ARB_FIXED_PRIO_EN for the expected pick order.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  parameter  int GAP = 8;

  logic             clk = 1'b0;
  logic             resetn;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic             tx_busy;
  logic [N-1:0]     grant;
  logic [W-1:0]     tx_data;
  logic             tx_start;
  logic             arb_busy;

  uart_tx_arbiter #(
    .NUM_REQ    (N),
    .DATA_W     (W),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .arb_busy (arb_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: cycle index, earliest idle cycle, fairness pointer, latched byte.
  int           cyc = 0;
  int           m_ready = 0;
  int           m_last = N - 1;
  logic [W-1:0] m_data = '0;
  logic [N-1:0] nxt_grant = '0;
  logic [N-1:0] exp_grant = '0;
  // TX model: busy high on cycles [rise, fall); external busy override.
  int           rise = 0;
  int           fall = 0;
  bit           ext_busy = 1'b0;
  int           tx_len = 4;
  int           dmax = 0;
  int           seen[$];

  function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
    return 0;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Drive tx_busy for the current cycle, predict the next cycle, advance one clock.
  task automatic step();
    int w;
    int d;
    tx_busy   = ext_busy || (cyc >= rise && cyc < fall);
    nxt_grant = '0;
    if (cyc >= m_ready && req != '0 && !tx_busy) begin
      w = pick(req, m_last);
      nxt_grant[w] = 1'b1;
      m_data = req_data[w*W +: W];
`ifndef UART_ARB_FIXED_PRIO_EN
      m_last = w;
`endif
      d = (dmax == 0) ? 0 : int'($urandom_range(0, dmax));
      rise = cyc + 2 + d;
      fall = rise + tx_len;
      m_ready = fall + GAP + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_grant = nxt_grant;
  endtask

  task automatic release_reset();
    resetn    = 1'b1;
    m_ready   = cyc;
    m_last    = N - 1;
    m_data    = '0;
    nxt_grant = '0;
    exp_grant = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req = '0; req_data = '0; tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (grant !== '0 || tx_start !== 1'b0 || tx_data !== '0 || arb_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset grant=%b start=%b data=%h busy=%b required all 0", grant, tx_start, tx_data, arb_busy);
    end
    release_reset();
  endtask

  task automatic test_single();
    int s;
    seen.delete();
    tx_len = 10; dmax = 0;
    req = 4'b0001; req_data[7:0] = 8'h41;
    s = cyc;
    for (int i = 0; i < 45; i++) begin
      step();
      checks++;
      if (grant !== exp_grant || tx_start !== (|exp_grant) || tx_data !== m_data || arb_busy !== (cyc < m_ready)) begin
        failures++;
        $display("FAIL single cyc=%0d grant=%b/%b start=%b data=%h/%h busy=%b/%b", cyc, grant, exp_grant, tx_start, tx_data, m_data, arb_busy, cyc < m_ready);
      end
      if (grant[0] === 1'b1) seen.push_back(cyc);
    end
    checks++;
    if (seen.size() < 2 || seen[0] != s + 1 || seen[1] - seen[0] != 3 + tx_len + GAP) begin
      failures++;
      $display("FAIL single_timing grants=%0d first=%0d required %0d spacing=%0d required %0d",
               seen.size(), seen.size() > 0 ? seen[0] : -1, s + 1,
               seen.size() > 1 ? seen[1] - seen[0] : -1, 3 + tx_len + GAP);
    end
    req = '0;
    repeat (40) step();
  endtask

  task automatic test_round_robin();
    int exp_seq[5];
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    resetn = 1'b0; #1; release_reset();
    seen.delete();
    dmax = 1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(8'h10 + i);
    req = '1;
    for (int i = 0; i < 300 && seen.size() < 5; i++) begin
      tx_len = $urandom_range(1, 5);
      step();
      checks++;
      if (grant !== exp_grant || tx_start !== (|exp_grant) || tx_data !== m_data || arb_busy !== (cyc < m_ready)) begin
        failures++;
        $display("FAIL rr cyc=%0d grant=%b/%b start=%b data=%h/%h busy=%b/%b", cyc, grant, exp_grant, tx_start, tx_data, m_data, arb_busy, cyc < m_ready);
      end
      if (grant !== '0) seen.push_back(onehot_idx(grant));
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= seen.size() || seen[k] != exp_seq[k]) begin
        failures++;
        $display("FAIL rr_order k=%0d got=%0d required=%0d", k, k < seen.size() ? seen[k] : -1, exp_seq[k]);
      end
    end
    req = '0;
    repeat (30) step();
  endtask

  task automatic test_skip();
    int exp_seq[3];
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_seq = '{1, 1, 1};
`else
    exp_seq = '{1, 3, 1};
`endif
    resetn = 1'b0; #1; release_reset();
    seen.delete();
    tx_len = 3; dmax = 0;
    req_data = 32'hD4C3B2A1;
    req = 4'b0010;
    for (int i = 0; i < 200 && seen.size() < 3; i++) begin
      step();
      checks++;
      if (grant !== exp_grant || tx_start !== (|exp_grant) || tx_data !== m_data || arb_busy !== (cyc < m_ready)) begin
        failures++;
        $display("FAIL skip cyc=%0d grant=%b/%b start=%b data=%h/%h busy=%b/%b", cyc, grant, exp_grant, tx_start, tx_data, m_data, arb_busy, cyc < m_ready);
      end
      if (grant !== '0) begin
        seen.push_back(onehot_idx(grant));
        req = 4'b1010;
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= seen.size() || seen[k] != exp_seq[k]) begin
        failures++;
        $display("FAIL skip_order k=%0d got=%0d required=%0d", k, k < seen.size() ? seen[k] : -1, exp_seq[k]);
      end
    end
    req = '0;
    repeat (30) step();
  endtask

  task automatic test_busy_idle();
    resetn = 1'b0; #1; release_reset();
    tx_len = 4; dmax = 0;
    ext_busy = 1'b1;
    req = 4'b0001; req_data[7:0] = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (grant !== '0 || tx_start !== 1'b0 || arb_busy !== 1'b0) begin
        failures++;
        $display("FAIL busy_hold cyc=%0d grant=%b start=%b busy=%b required 0", cyc, grant, tx_start, arb_busy);
      end
    end
    ext_busy = 1'b0;
    step();
    checks++;
    if (grant !== 4'b0001 || tx_start !== 1'b1 || tx_data !== 8'h5A) begin
      failures++;
      $display("FAIL busy_release grant=%b start=%b data=%h required 0001 1 5a", grant, tx_start, tx_data);
    end
    req = '0;
    repeat (30) begin
      step();
      checks++;
      if (grant !== exp_grant || tx_start !== (|exp_grant) || tx_data !== m_data || arb_busy !== (cyc < m_ready)) begin
        failures++;
        $display("FAIL busy_tail cyc=%0d grant=%b/%b start=%b data=%h/%h busy=%b/%b", cyc, grant, exp_grant, tx_start, tx_data, m_data, arb_busy, cyc < m_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    int g;
    resetn = 1'b0; #1; release_reset();
    tx_len = 8; dmax = 0;
    req = 4'b0001; req_data[7:0] = 8'h77;
    g = -1;
    for (int i = 0; i < 10 && g < 0; i++) begin
      step();
      if (grant !== '0) g = cyc;
    end
    checks++;
    if (g < 0) begin
      failures++;
      $display("FAIL reset_mid_grant got=none required a grant within 10 cycles");
    end
    req = 4'b0100; req_data[23:16] = 8'h99;
    repeat (4) step();
    checks++;
    if (arb_busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre arb_busy=%b required 1", arb_busy);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || tx_start !== 1'b0 || tx_data !== '0 || arb_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid grant=%b start=%b data=%h busy=%b required all 0", grant, tx_start, tx_data, arb_busy);
    end
    release_reset();
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (grant !== exp_grant || tx_start !== (|exp_grant) || tx_data !== m_data || arb_busy !== (cyc < m_ready)) begin
        failures++;
        $display("FAIL reset_mid_tail cyc=%0d grant=%b/%b start=%b data=%h/%h busy=%b/%b", cyc, grant, exp_grant, tx_start, tx_data, m_data, arb_busy, cyc < m_ready);
      end
      if (grant !== '0) req = '0;
    end
    req = '0;
    repeat (30) step();
  endtask

  task automatic test_random();
    resetn = 1'b0; #1; release_reset();
    req = '0; dmax = 2;
    for (int i = 0; i < 1500; i++) begin
      tx_len   = $urandom_range(1, 6);
      ext_busy = (cyc >= m_ready) && ($urandom_range(0, 7) == 0);
      step();
      checks++;
      if (grant !== exp_grant || tx_start !== (|exp_grant) || tx_data !== m_data || arb_busy !== (cyc < m_ready)) begin
        failures++;
        $display("FAIL random cyc=%0d grant=%b/%b start=%b data=%h/%h busy=%b/%b", cyc, grant, exp_grant, tx_start, tx_data, m_data, arb_busy, cyc < m_ready);
      end
      for (int r = 0; r < N; r++) begin
        if (exp_grant[r]) begin
          if ($urandom_range(0, 1) == 0) req[r] = 1'b0;
        end else if (!req[r]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_data[r*W +: W] = W'($urandom);
            req[r] = 1'b1;
          end
        end else if ($urandom_range(0, 63) == 0) begin
          req[r] = 1'b0;
        end
      end
    end
    ext_busy = 1'b0;
    req = '0;
    repeat (40) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_skip();
    test_busy_idle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte producers; the producers are sender-style blocks.
- Picks a requester with a round-robin scheme, then latches its byte and pulses the start strobe toward the TX.
- Follows the TX busy flag through the whole transmission, then inserts a programmable idle gap before the next arbitration.
- Sits between the producer blocks and the UART TX core in the top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- GAP_CYCLES, 8, idle clocks inserted after each transmitted byte; 0 means no gap.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low; one clock domain.
- req  in  NUM_REQ  level request per requester; held until granted.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies [i*DATA_W +: DATA_W]; stable while req[i]=1.
- grant  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted.
- tx_busy  in  1  UART TX busy flag.
- tx_data  out  DATA_W  byte presented to the TX.
- tx_start  out  1  one-cycle start strobe to the TX.
- arb_busy  out  1  high whenever the FSM is not in sIDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=sIDLE.
  - Outputs: grant=0, tx_start=0, tx_data=0, arb_busy=0.
  - Internal: gap counter=0, last_idx=NUM_REQ-1, so requester 0 wins first.
- sIDLE:
  - If |req and !tx_busy: winner = first set req scanning from last_idx+1 upward, wrapping modulo NUM_REQ.
  - Registered on the same edge: tx_data<=winner byte, grant[winner]<=1, tx_start<=1, last_idx<=winner, next state sSEND.
  - Otherwise stay in sIDLE.
  - Latency: req asserted on cycle N gives grant and tx_start high during cycle N+1.
- sSEND:
  - grant and tx_start return to 0 after one cycle.
  - Wait for tx_busy=1, then go to sDRAIN.
  - If tx_busy is already 1 on the first sSEND cycle, go to sDRAIN next cycle.
- sDRAIN: wait for tx_busy=0.
  - Then go to sGAP if GAP_CYCLES>0, else to sIDLE.
- sGAP:
  - Counter increments each clock; at GAP_CYCLES-1 it clears and the FSM goes to sIDLE.
  - Gap length is exactly GAP_CYCLES clocks.
  - Counter width is $clog2(GAP_CYCLES+1), minimum 1.
- tx_data holds the latched byte from grant until the next grant; it is not cleared in sIDLE.
- At most one grant bit is high in any cycle; grant never asserts outside the sIDLE->sSEND transition.
- Requesters whose req drops before being granted are simply skipped; no state is kept for them.
- If req[winner] is still asserted after a grant, it is treated as a new byte; fairness comes from last_idx.
- Unused state encodings go to sIDLE.
- If resetn is asserted mid-byte, tx_start and grant drop at once; the TX finishes on its own.

Optional Feature:
- Macro: UART_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; last_idx is not updated (it may be optimised away).
- Undefined (default): round-robin as described above.

Decomposition:
- Package uart_arb_pkg:
  - State localparams sIDLE=2'd0, sSEND=2'd1, sDRAIN=2'd2, sGAP=2'd3.
  - Default DATA_W constant.
- Sub-module rr_picker:
  - Combinational; inputs req and last_idx; outputs a valid flag and the winner index.
  - Contains the macro-selected fixed-priority variant.
- FSM, counter and output registers live in uart_tx_arbiter.

Test Plan:
- Reset then req=4'b0001, data0=8'h41, TX raises busy 1 cycle after start and holds it 10 cycles -> grant=0001 and tx_start pulse on cycle 1, tx_data=8'h41; next grant no earlier than 10+8 cycles after busy.
- req=4'b1111 held continuously, distinct data -> grants in order 0001,0010,0100,1000,0001; tx_data follows each byte.
- req=4'b1010 with last grant=1 -> next grant 1000, then 0010.
- tx_busy=1 while in sIDLE with req=0001 -> no grant until busy falls, then grant on the following cycle.
- GAP_CYCLES=0 build -> sDRAIN goes straight to sIDLE; the next grant occurs 2 cycles after busy falls.
- resetn pulsed low during sDRAIN -> all outputs 0 immediately, arb_busy=0; UART_ARB_FIXED_PRIO_EN build with req=1111 -> every grant is 0001.
